// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller
//  Brief    : Multi-cycle control FSM for the RV32IM core (ALU, MU, dmem, WB).
//  Revision : 1.0  initial release
// ============================================================================
module mc_controller #(
    parameter int pcmux_N     = 4,
    parameter int ifuresctl_N = 4,
    parameter bit MUL_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [6:0]                     func7,
    input  logic                           alu_zero,
    input  logic                           alu_lt,
    input  logic                           alu_ltu,
    input  logic                           mul_done,
    input  logic                           mem_ready,
    output logic [$clog2(pcmux_N)-1:0]     pcctl,
    output logic                           pcwe,
    output logic                           regwe,
    output logic                           alusrca,
    output logic                           alusrcb,
    output logic [3:0]                     aluctl,
    output logic [1:0]                     mulctl,
    output logic                           mul_start,
    output logic                           memre,
    output logic                           memwe,
    output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
    output logic                           illegal
);

    localparam int c_PCW = $clog2(pcmux_N);
    localparam int c_RSW = $clog2(ifuresctl_N);

    localparam logic [6:0] c_OP_OP     = 7'h33;
    localparam logic [6:0] c_OP_OPIMM  = 7'h13;
    localparam logic [6:0] c_OP_LUI    = 7'h37;
    localparam logic [6:0] c_OP_AUIPC  = 7'h17;
    localparam logic [6:0] c_OP_JAL    = 7'h6F;
    localparam logic [6:0] c_OP_JALR   = 7'h67;
    localparam logic [6:0] c_OP_BRANCH = 7'h63;
    localparam logic [6:0] c_OP_LOAD   = 7'h03;
    localparam logic [6:0] c_OP_STORE  = 7'h23;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    localparam logic [c_PCW-1:0] c_PC_PLUS4 = c_PCW'(0);
    localparam logic [c_PCW-1:0] c_PC_IMM   = c_PCW'(1);
    localparam logic [c_PCW-1:0] c_PC_ALU   = c_PCW'(2);
    localparam logic [c_PCW-1:0] c_PC_TRAP  = c_PCW'(3);

    localparam logic [c_RSW-1:0] c_RES_ALU  = c_RSW'(0);
    localparam logic [c_RSW-1:0] c_RES_MU   = c_RSW'(1);
    localparam logic [c_RSW-1:0] c_RES_MEM  = c_RSW'(2);
    localparam logic [c_RSW-1:0] c_RES_PC4  = c_RSW'(3);

    localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MUL   = 3'd2,
        S_MEM   = 3'd3,
        S_TRAP  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        K_ILL    = 3'd0,
        K_ALU    = 3'd1,
        K_JUMP   = 3'd2,
        K_BRANCH = 3'd3,
        K_MEM    = 3'd4,
        K_MUL    = 3'd5
    } kind_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_count;
    logic [7:0]       w_count_next;
    logic             r_illegal;
    logic [6:0]       r_opcode;
    logic [2:0]       r_func3;
    logic [6:0]       r_func7;

    kind_t            w_kind;
    logic [3:0]       w_base_alu;
    logic [3:0]       w_dec_aluctl;
    logic             w_dec_srca;
    logic             w_dec_srcb;
    logic [c_PCW-1:0] w_dec_pcctl;
    logic             w_is_load;
    logic             w_f7_std;
    logic             w_taken;
    logic [7:0]       w_count_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_opcode  <= '0;
            r_func3   <= '0;
            r_func7   <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (r_state == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (instr_valid && instr_ready) begin
                r_opcode <= opcode;
                r_func3  <= func3;
                r_func7  <= func7;
            end
        end
    end

    // func7 of 0x00 or 0x20 is the only legal pattern for the shift/SUB variants
    assign w_f7_std    = (r_func7 & 7'b1011111) == 7'h00;
    assign w_is_load   = (r_opcode == c_OP_LOAD);
    assign w_count_inc = r_count + 8'd1;
    assign illegal     = rst_n & r_illegal;

    always_comb begin
        w_base_alu = c_ALU_ADD;
        case (r_func3)
            3'd0:    w_base_alu = c_ALU_ADD;
            3'd1:    w_base_alu = c_ALU_SLL;
            3'd2:    w_base_alu = c_ALU_SLT;
            3'd3:    w_base_alu = c_ALU_SLTU;
            3'd4:    w_base_alu = c_ALU_XOR;
            3'd5:    w_base_alu = c_ALU_SRL;
            3'd6:    w_base_alu = c_ALU_OR;
            default: w_base_alu = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_kind       = K_ILL;
        w_dec_aluctl = c_ALU_ADD;
        w_dec_srca   = 1'b0;
        w_dec_srcb   = 1'b0;
        w_dec_pcctl  = c_PC_IMM;
        case (r_opcode)
            c_OP_OP: begin
                if (r_func7 == 7'h01) begin
                    if (MUL_EN && !r_func3[2]) begin
                        w_kind = K_MUL;
                    end
                end else if (w_f7_std && (!r_func7[5] || r_func3 == 3'd0 || r_func3 == 3'd5)) begin
                    w_kind = K_ALU;
                    if (!r_func7[5]) begin
                        w_dec_aluctl = w_base_alu;
                    end else begin
                        w_dec_aluctl = (r_func3 == 3'd0) ? c_ALU_SUB : c_ALU_SRA;
                    end
                end
            end
            c_OP_OPIMM: begin
                // func7 is immediate data except for the shift encodings
                w_kind       = K_ALU;
                w_dec_srcb   = 1'b1;
                w_dec_aluctl = w_base_alu;
                if (r_func3 == 3'd1 && r_func7 != 7'h00) begin
                    w_kind = K_ILL;
                end
                if (r_func3 == 3'd5) begin
                    if (!w_f7_std) begin
                        w_kind = K_ILL;
                    end else if (r_func7[5]) begin
                        w_dec_aluctl = c_ALU_SRA;
                    end
                end
            end
            c_OP_LUI: begin
                w_kind       = K_ALU;
                w_dec_aluctl = c_ALU_PASSB;
                w_dec_srcb   = 1'b1;
            end
            c_OP_AUIPC: begin
                w_kind     = K_ALU;
                w_dec_srca = 1'b1;
                w_dec_srcb = 1'b1;
            end
            c_OP_JAL: begin
                w_kind = K_JUMP;
            end
            c_OP_JALR: begin
                if (r_func3 == 3'd0) begin
                    w_kind      = K_JUMP;
                    w_dec_pcctl = c_PC_ALU;
                    w_dec_srcb  = 1'b1;
                end
            end
            c_OP_BRANCH: begin
                if (r_func3[2:1] != 2'b01) begin
                    w_kind       = K_BRANCH;
                    w_dec_aluctl = c_ALU_SUB;
                end
            end
            c_OP_LOAD: begin
                if (r_func3 != 3'd3 && r_func3 != 3'd6 && r_func3 != 3'd7) begin
                    w_kind     = K_MEM;
                    w_dec_srcb = 1'b1;
                end
            end
            c_OP_STORE: begin
                if (!r_func3[2] && r_func3[1:0] != 2'b11) begin
                    w_kind     = K_MEM;
                    w_dec_srcb = 1'b1;
                end
            end
            default: w_kind = K_ILL;
        endcase
    end

    // func3[0] inverts the base condition (BNE/BGE/BGEU)
    always_comb begin
        w_taken = 1'b0;
        case (r_func3[2:1])
            2'b00:   w_taken = alu_zero;
            2'b10:   w_taken = alu_lt;
            2'b11:   w_taken = alu_ltu;
            default: w_taken = 1'b0;
        endcase
        w_taken = w_taken ^ r_func3[0];
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        instr_ready  = 1'b0;
        pcctl        = c_PC_PLUS4;
        pcwe         = 1'b0;
        regwe        = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 1'b0;
        aluctl       = c_ALU_ADD;
        mulctl       = 2'd0;
        mul_start    = 1'b0;
        memre        = 1'b0;
        memwe        = 1'b0;
        ifuresctl    = c_RES_ALU;
        // while reset is low every strobe stays quiet, so an in-flight op never commits
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        w_state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_kind)
                        K_ALU: begin
                            aluctl       = w_dec_aluctl;
                            alusrca      = w_dec_srca;
                            alusrcb      = w_dec_srcb;
                            regwe        = 1'b1;
                            ifuresctl    = c_RES_ALU;
                            pcwe         = 1'b1;
                            pcctl        = c_PC_PLUS4;
                            w_state_next = S_FETCH;
                        end
                        K_JUMP: begin
                            alusrcb      = w_dec_srcb;
                            regwe        = 1'b1;
                            ifuresctl    = c_RES_PC4;
                            pcwe         = 1'b1;
                            pcctl        = w_dec_pcctl;
                            w_state_next = S_FETCH;
                        end
                        K_BRANCH: begin
                            aluctl       = w_dec_aluctl;
                            pcwe         = 1'b1;
                            pcctl        = w_taken ? c_PC_IMM : c_PC_PLUS4;
                            w_state_next = S_FETCH;
                        end
                        K_MEM: begin
                            alusrcb      = 1'b1;
                            w_count_next = '0;
                            w_state_next = S_MEM;
                        end
                        K_MUL: begin
                            mul_start    = 1'b1;
                            mulctl       = r_func3[1:0];
                            w_state_next = S_MUL;
                        end
                        default: w_state_next = S_TRAP;
                    endcase
                end
                S_MUL: begin
                    mulctl = r_func3[1:0];
                    if (mul_done) begin
                        regwe        = 1'b1;
                        ifuresctl    = c_RES_MU;
                        pcwe         = 1'b1;
                        pcctl        = c_PC_PLUS4;
                        w_state_next = S_FETCH;
                    end
                end
                S_MEM: begin
                    alusrcb = 1'b1;
                    memre   = w_is_load;
                    memwe   = !w_is_load;
                    // completion is checked first so a ready on the limit cycle still commits
                    if (mem_ready) begin
                        regwe        = w_is_load;
                        ifuresctl    = w_is_load ? c_RES_MEM : c_RES_ALU;
                        pcwe         = 1'b1;
                        pcctl        = c_PC_PLUS4;
                        w_count_next = '0;
                        w_state_next = S_FETCH;
                    end else if (w_count_inc == c_TIMEOUT) begin
                        w_count_next = '0;
                        w_state_next = S_TRAP;
                    end else begin
                        w_count_next = w_count_inc;
                    end
                end
                S_TRAP: begin
                    if (!r_illegal) begin
                        pcwe  = 1'b1;
                        pcctl = c_PC_TRAP;
                    end
                end
                default: w_state_next = S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_controller
//  Brief    : Directed scoreboard bench for mc_controller (MEM_TIMEOUT=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       alu_zero, alu_lt, alu_ltu;
    logic       mul_done, mem_ready;
    logic [1:0] pcctl;
    logic       pcwe, regwe, alusrca, alusrcb;
    logic [3:0] aluctl;
    logic [1:0] mulctl;
    logic       mul_start, memre, memwe;
    logic [1:0] ifuresctl;
    logic       illegal;

    mc_controller #(
        .pcmux_N     (4),
        .ifuresctl_N (4),
        .MUL_EN      (1'b1),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .alu_ltu     (alu_ltu),
        .mul_done    (mul_done),
        .mem_ready   (mem_ready),
        .pcctl       (pcctl),
        .pcwe        (pcwe),
        .regwe       (regwe),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .aluctl      (aluctl),
        .mulctl      (mulctl),
        .mul_start   (mul_start),
        .memre       (memre),
        .memwe       (memwe),
        .ifuresctl   (ifuresctl),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       instr_ready;
        logic [1:0] pcctl;
        logic       pcwe;
        logic       regwe;
        logic       alusrca;
        logic       alusrcb;
        logic [3:0] aluctl;
        logic [1:0] mulctl;
        logic       mul_start;
        logic       memre;
        logic       memwe;
        logic [1:0] ifuresctl;
        logic       illegal;
    } outs_t;

    string tag_q[$];
    outs_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic outs_t observe();
        outs_t o;
        o.instr_ready = instr_ready;
        o.pcctl       = pcctl;
        o.pcwe        = pcwe;
        o.regwe       = regwe;
        o.alusrca     = alusrca;
        o.alusrcb     = alusrcb;
        o.aluctl      = aluctl;
        o.mulctl      = mulctl;
        o.mul_start   = mul_start;
        o.memre       = memre;
        o.memwe       = memwe;
        o.ifuresctl   = ifuresctl;
        o.illegal     = illegal;
        return o;
    endfunction

    function automatic outs_t fetch_e();
        outs_t e = '0;
        e.instr_ready = 1'b1;
        return e;
    endfunction

    function automatic outs_t alu_e(input logic [3:0] ctl, input logic sa, input logic sb);
        outs_t e = '0;
        e.aluctl  = ctl;
        e.alusrca = sa;
        e.alusrcb = sb;
        e.regwe   = 1'b1;
        e.pcwe    = 1'b1;
        return e;
    endfunction

    function automatic outs_t mem_e(input logic rd);
        outs_t e = '0;
        e.alusrcb = 1'b1;
        e.memre   = rd;
        e.memwe   = !rd;
        return e;
    endfunction

    // Push expectation for this cycle, then pop and compare at the falling edge.
    task automatic cycle(input string tag, input outs_t e);
        outs_t o;
        outs_t x;
        string t;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(negedge clk);
        o = observe();
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, o, x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        opcode      = op;
        func3       = f3;
        func7       = f7;
        instr_valid = 1'b1;
        cycle(tag, fetch_e());
        instr_valid = 1'b0;
        opcode      = '0;
        func3       = '0;
        func7       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        outs_t e;
        rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; func3 = '0; func7 = '0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mul_done = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle("rst0", '0);
        cycle("rst1", '0);
        rst_n = 1'b1;

        // ALU class
        issue("addi_fetch", 7'h13, 3'd0, 7'h00);
        cycle("addi_exec", alu_e(4'd0, 1'b0, 1'b1));
        issue("addi_neg_fetch", 7'h13, 3'd0, 7'h20);
        cycle("addi_neg_exec", alu_e(4'd0, 1'b0, 1'b1));
        issue("sub_fetch", 7'h33, 3'd0, 7'h20);
        cycle("sub_exec", alu_e(4'd1, 1'b0, 1'b0));
        issue("srai_fetch", 7'h13, 3'd5, 7'h20);
        cycle("srai_exec", alu_e(4'd7, 1'b0, 1'b1));
        issue("and_fetch", 7'h33, 3'd7, 7'h00);
        cycle("and_exec", alu_e(4'd9, 1'b0, 1'b0));
        issue("lui_fetch", 7'h37, 3'd0, 7'h00);
        cycle("lui_exec", alu_e(4'd10, 1'b0, 1'b1));
        issue("auipc_fetch", 7'h17, 3'd0, 7'h00);
        cycle("auipc_exec", alu_e(4'd0, 1'b1, 1'b1));

        // jumps
        issue("jal_fetch", 7'h6F, 3'd0, 7'h00);
        e = '0; e.regwe = 1'b1; e.ifuresctl = 2'd3; e.pcwe = 1'b1; e.pcctl = 2'd1;
        cycle("jal_exec", e);
        issue("jalr_fetch", 7'h67, 3'd0, 7'h00);
        e = '0; e.regwe = 1'b1; e.ifuresctl = 2'd3; e.pcwe = 1'b1; e.pcctl = 2'd2; e.alusrcb = 1'b1;
        cycle("jalr_exec", e);

        // branches
        issue("bne_fetch", 7'h63, 3'd1, 7'h00);
        alu_zero = 1'b0;
        e = '0; e.aluctl = 4'd1; e.pcwe = 1'b1; e.pcctl = 2'd1;
        cycle("bne_taken", e);
        issue("bge_fetch", 7'h63, 3'd5, 7'h00);
        alu_lt = 1'b1;
        e = '0; e.aluctl = 4'd1; e.pcwe = 1'b1; e.pcctl = 2'd0;
        cycle("bge_not_taken", e);
        issue("bltu_fetch", 7'h63, 3'd6, 7'h00);
        alu_ltu = 1'b1;
        e = '0; e.aluctl = 4'd1; e.pcwe = 1'b1; e.pcctl = 2'd1;
        cycle("bltu_taken", e);
        alu_lt = 1'b0; alu_ltu = 1'b0;

        // MULHU with 5-cycle MU latency; a stray mul_done in fetch is ignored
        mul_done = 1'b1;
        issue("mulhu_fetch", 7'h33, 3'd3, 7'h01);
        mul_done = 1'b0;
        e = '0; e.mul_start = 1'b1; e.mulctl = 2'd3;
        cycle("mulhu_start", e);
        e = '0; e.mulctl = 2'd3;
        for (int i = 0; i < 4; i++) cycle("mulhu_wait", e);
        mul_done = 1'b1;
        e = '0; e.mulctl = 2'd3; e.regwe = 1'b1; e.ifuresctl = 2'd1; e.pcwe = 1'b1;
        cycle("mulhu_done", e);
        mul_done = 1'b0;

        // LW, ready after 3 wait cycles
        issue("lw_fetch", 7'h03, 3'd2, 7'h00);
        e = '0; e.alusrcb = 1'b1;
        cycle("lw_exec", e);
        for (int i = 0; i < 3; i++) cycle("lw_wait", mem_e(1'b1));
        mem_ready = 1'b1;
        e = mem_e(1'b1); e.regwe = 1'b1; e.ifuresctl = 2'd2; e.pcwe = 1'b1;
        cycle("lw_done", e);
        mem_ready = 1'b0;

        // LW, ready exactly on the timeout cycle
        issue("lwlim_fetch", 7'h03, 3'd2, 7'h00);
        e = '0; e.alusrcb = 1'b1;
        cycle("lwlim_exec", e);
        for (int i = 0; i < 7; i++) cycle("lwlim_wait", mem_e(1'b1));
        mem_ready = 1'b1;
        e = mem_e(1'b1); e.regwe = 1'b1; e.ifuresctl = 2'd2; e.pcwe = 1'b1;
        cycle("lwlim_done", e);
        mem_ready = 1'b0;
        cycle("lwlim_after", fetch_e());

        // SW, never ready -> timeout trap
        issue("sw_fetch", 7'h23, 3'd2, 7'h00);
        e = '0; e.alusrcb = 1'b1;
        cycle("sw_exec", e);
        for (int i = 0; i < 8; i++) cycle("sw_wait", mem_e(1'b0));
        e = '0; e.pcwe = 1'b1; e.pcctl = 2'd3;
        cycle("sw_trap_entry", e);
        instr_valid = 1'b1; opcode = 7'h13; mem_ready = 1'b1;
        e = '0; e.illegal = 1'b1;
        cycle("sw_trap_sticky", e);
        cycle("sw_trap_sticky2", e);
        instr_valid = 1'b0; opcode = '0; mem_ready = 1'b0;
        rst_n = 1'b0;
        cycle("trap_rst", '0);
        rst_n = 1'b1;

        // illegal branch func3
        issue("b010_fetch", 7'h63, 3'd2, 7'h00);
        cycle("b010_exec", '0);
        e = '0; e.pcwe = 1'b1; e.pcctl = 2'd3;
        cycle("b010_trap_entry", e);
        e = '0; e.illegal = 1'b1;
        cycle("b010_illegal", e);
        rst_n = 1'b0;
        cycle("b010_rst", '0);
        rst_n = 1'b1;

        // DIV is not supported
        issue("div_fetch", 7'h33, 3'd4, 7'h01);
        cycle("div_exec", '0);
        e = '0; e.pcwe = 1'b1; e.pcctl = 2'd3;
        cycle("div_trap_entry", e);
        rst_n = 1'b0;
        cycle("div_rst", '0);
        rst_n = 1'b1;

        // reset while waiting on the MU
        issue("rmul_fetch", 7'h33, 3'd1, 7'h01);
        e = '0; e.mul_start = 1'b1; e.mulctl = 2'd1;
        cycle("rmul_start", e);
        e = '0; e.mulctl = 2'd1;
        cycle("rmul_wait", e);
        rst_n = 1'b0; mul_done = 1'b1;
        cycle("rmul_rst_low", '0);
        rst_n = 1'b1;
        cycle("rmul_fetch_again", fetch_e());
        mul_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
